// File: rtl/lupa_spi_master.sv
// LUPA sensor SPI register master: one {rw, addr, data} frame per command,
// programmable bit rate, read data captured from spi_miso.
module lupa_spi_master #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 2,
  parameter int GAP_CYC   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clock_20,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              spi_clk,
  output logic              spi_en,
  output logic              spi_dat,
  input  logic              spi_miso
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int BW      = $clog2(FRAME_W + 1);
  localparam int CMAX    = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC - 1);
  localparam logic [BW-1:0] BIT_END = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] DAT_BEG = BW'(1 + ADDR_W);

  typedef enum logic [2:0] {
    IDLE, LO, HI, TRAIL, GAP
  } state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bit_idx;
  logic [FRAME_W-1:0]  sr;
  logic [DATA_W-1:0]   cap;
  logic                is_rd;
  logic                cur_bit;

  always_ff @(posedge clock_20 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (cmd_valid) state_nx = LO;
      LO:    if (cnt == DIV_END) state_nx = HI;
      HI:    if (cnt == DIV_END)
               state_nx = (bit_idx == BIT_END) ? TRAIL : LO;
      TRAIL: if (cnt == DIV_END) state_nx = GAP;
      GAP:   if (cnt == GAP_END) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_20 or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
      cap     <= '0;
      is_rd   <= 1'b0;
      rd_data <= '0;
    end else begin
      cnt <= (state_nx != state) ? '0 : cnt + CW'(1);
      unique case (state)
        IDLE: if (cmd_valid) begin
          sr      <= {cmd_rw, cmd_addr, cmd_wdata & {DATA_W{cmd_rw}}};
          is_rd   <= ~cmd_rw;
          bit_idx <= '0;
          cap     <= '0;
        end
        HI: begin
          // sample miso once, on the spi_clk rising cycle
          if (cnt == '0 && is_rd && bit_idx >= DAT_BEG)
            cap <= {cap[DATA_W-2:0], spi_miso};
          if (state_nx == LO) begin
            sr <= MSB_FIRST ? {sr[FRAME_W-2:0], 1'b0}
                            : {1'b0, sr[FRAME_W-1:1]};
            bit_idx <= bit_idx + BW'(1);
          end
        end
        TRAIL: if (state_nx == GAP && is_rd) rd_data <= cap;
        default: ;
      endcase
    end
  end

  assign cur_bit = MSB_FIRST ? sr[FRAME_W-1] : sr[0];

  always_comb begin
    cmd_ready = 1'b0;
    spi_en    = 1'b0;
    spi_clk   = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:  cmd_ready = 1'b1;
      LO:    spi_en = 1'b1;
      HI:    begin spi_en = 1'b1; spi_clk = 1'b1; end
      TRAIL: spi_en = 1'b1;
      GAP:   done = (cnt == '0);
      default: ;
    endcase
    busy     = ~cmd_ready;
    rd_valid = done & is_rd;
    spi_dat  = spi_en & cur_bit;
  end

endmodule
